eeg_load_ctrl: RTL and testbench

Sequences loading one sleep epoch of raw EEG samples from the SoC interface into intermediate-results memory before inference starts. Converts each unsigned ADC sample to signed fixed point. Writes the samples to consecutive addresses through a req/gnt write port shared with the compute datapath. Sits between SoCInterface (start_eeg_load, new_eeg_data, eeg) and the int-res memory arbiter inside cim_centralized.

---
 rtl/eeg_load_ctrl_pkg.sv | 23 ++
 rtl/eeg_sample_buf.sv | 66 ++++++
 rtl/eeg_load_ctrl.sv | 145 ++++++++++++++
 tb/tb_eeg_load_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeg_load_ctrl_pkg.sv
// Shared definitions for the EEG epoch loader: data types, FSM state encodings
// and epoch geometry used by eeg_load_ctrl and its sample buffer.
package eeg_load_ctrl_pkg;

  localparam int unsigned ADC_DATA_W   = 16;
  localparam int unsigned COMP_FX_W    = 22;
  localparam int unsigned INT_RES_AW   = 16;

  typedef logic [ADC_DATA_W-1:0] adc_data_t;
  typedef logic [COMP_FX_W-1:0]  comp_fx_t;
  typedef logic [INT_RES_AW-1:0] int_res_addr_t;

  // Loader FSM encoding (kept as plain constants for legacy tools)
  typedef logic [1:0] eeg_load_state_t;
  localparam eeg_load_state_t ST_IDLE = 2'd0;
  localparam eeg_load_state_t ST_LOAD = 2'd1;
  localparam eeg_load_state_t ST_DONE = 2'd2;

  localparam int unsigned NUM_SAMPLES_PER_EPOCH = 3000;  // 30 s at 100 Hz
  localparam int unsigned EEG_BASE_ADDR         = 0;
  localparam int unsigned EEG_FRAC_SHIFT        = 4;

endpackage

// File: rtl/eeg_sample_buf.sv
// One-entry holding register between the EEG sample source and the shared
// int-res write port. A push while full with no pop in the same cycle is
// dropped and recorded in a sticky overrun flag.
module eeg_sample_buf #(
  parameter int unsigned W = 22
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,      // discard entry and clear overrun
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,        // write granted this cycle
  output logic         valid,
  output logic [W-1:0] data,
  output logic         overrun
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         overrun_q, overrun_d;
  logic         accept;
  logic         drop;

  // A pop frees the slot at the same edge, so a coincident push still fits
  assign accept = push && (!valid_q || pop);
  assign drop   = push && valid_q && !pop;

  // Next-state for occupancy, payload and sticky overrun
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    if (flush) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (accept) begin
        valid_d = 1'b1;
        data_d  = push_data;
      end else if (pop) begin
        valid_d = 1'b0;
      end
      if (drop) begin
        overrun_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid   = valid_q;
  assign data    = data_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/eeg_load_ctrl.sv
// EEG epoch loader: converts unsigned ADC samples to signed fixed point and
// writes one epoch to consecutive int-res addresses over a req/gnt port.
// Optional build macro EEG_LOAD_STALL_CNT_EN adds a saturating stall_cycles
// counter of cycles with mem_req high and mem_gnt low.
module eeg_load_ctrl
  import eeg_load_ctrl_pkg::*;
#(
  parameter int unsigned ADC_W       = ADC_DATA_W,
  parameter int unsigned DATA_W      = COMP_FX_W,
  parameter int unsigned ADDR_W      = INT_RES_AW,
  parameter int unsigned FRAC_SHIFT  = EEG_FRAC_SHIFT,
  parameter int unsigned NUM_SAMPLES = NUM_SAMPLES_PER_EPOCH,
  parameter int unsigned BASE_ADDR   = EEG_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_eeg_load,
  input  logic              new_eeg_data,
  input  logic [ADC_W-1:0]  eeg,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              loading,
  output logic              load_done,
  output logic              overrun,
`ifdef EEG_LOAD_STALL_CNT_EN
  output logic [15:0]       stall_cycles,
`endif
  output logic [11:0]       sample_cnt
);

  // Intermediate width large enough to hold the shifted sample plus a sign
  // guard, so saturation can be decided without losing bits.
  localparam int unsigned RAW_W = ADC_W + FRAC_SHIFT;
  localparam int unsigned WW    = ((RAW_W > DATA_W) ? RAW_W : DATA_W) + 1;

  eeg_load_state_t state_q, state_d;
  logic [11:0]     cnt_q, cnt_d;
  logic            done_q, done_d;

  logic              buf_valid;
  logic              buf_overrun;
  logic              buf_push;
  logic              grant;
  logic              last_grant;
  logic              in_load;

  logic [ADC_W-1:0]  offset;
  logic signed [WW-1:0] wide;
  logic signed [WW-1:0] sat_max;
  logic signed [WW-1:0] sat_min;
  logic [DATA_W-1:0] conv;

  // Subtracting mid-scale from an unsigned code is an MSB flip
  assign offset  = {~eeg[ADC_W-1], eeg[ADC_W-2:0]};
  assign wide    = $signed({{(WW-ADC_W){offset[ADC_W-1]}}, offset}) <<< FRAC_SHIFT;
  assign sat_max = $signed({{(WW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  assign sat_min = $signed({{(WW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

  // Saturate the shifted sample to the signed DATA_W range
  always_comb begin
    conv = wide[DATA_W-1:0];
    if (wide > sat_max) begin
      conv = sat_max[DATA_W-1:0];
    end else if (wide < sat_min) begin
      conv = sat_min[DATA_W-1:0];
    end
  end

  assign in_load    = (state_q == ST_LOAD);
  assign grant      = buf_valid && mem_gnt;
  assign last_grant = in_load && grant && (cnt_q == 12'(NUM_SAMPLES - 1));
  // No sample may be captured once the epoch completes or on a (re)start
  assign buf_push   = in_load && new_eeg_data && !start_eeg_load && !last_grant;

  eeg_sample_buf #(
    .W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (start_eeg_load),
    .push      (buf_push),
    .push_data (conv),
    .pop       (grant),
    .valid     (buf_valid),
    .data      (mem_data),
    .overrun   (buf_overrun)
  );

  // FSM, sample counter and done pulse next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (start_eeg_load) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
    end else if (in_load && grant) begin
      cnt_d = cnt_q + 12'd1;
      if (last_grant) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef EEG_LOAD_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of cycles the shared port holds off our request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_eeg_load) begin
      stall_q <= '0;
    end else if (buf_valid && !mem_gnt && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

  assign mem_req    = buf_valid;
  assign mem_addr   = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt_q);
  assign loading    = in_load;
  assign load_done  = done_q;
  assign overrun    = buf_overrun;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_eeg_load_ctrl.sv
// Scoreboard bench for eeg_load_ctrl: each accepted sample pushes its expected
// address/data, and every granted write is popped and compared.
module tb_eeg_load_ctrl;

  localparam int BASE = 0;

  logic        clk;
  logic        rst_n;
  logic        start_eeg_load;
  logic        new_eeg_data;
  logic [15:0] eeg;
  logic        mem_req;
  logic        mem_gnt;
  logic [15:0] mem_addr;
  logic [21:0] mem_data;
  logic        loading;
  logic        load_done;
  logic        overrun;
  logic [11:0] sample_cnt;
`ifdef EEG_LOAD_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  eeg_load_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_eeg_load (start_eeg_load),
    .new_eeg_data   (new_eeg_data),
    .eeg            (eeg),
    .mem_req        (mem_req),
    .mem_gnt        (mem_gnt),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .loading        (loading),
    .load_done      (load_done),
    .overrun        (overrun),
`ifdef EEG_LOAD_STALL_CNT_EN
    .stall_cycles   (stall_cycles),
`endif
    .sample_cnt     (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  exp_idx  = 0;
  int  wr_cnt   = 0;
  int  done_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int conv_model(input logic [15:0] s);
    int v;
    v = (int'(s) - 32768) * 16;
    if (v > 2097151) v = 2097151;
    if (v < -2097152) v = -2097152;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_eeg_load = 1'b1;
    tick();
    start_eeg_load = 1'b0;
    exp_idx = 0;
  endtask

  // Drive one sample pulse; accept says whether the sample should be written
  task automatic send(input logic [15:0] s, input bit accept);
    wr_t w;
    eeg = s;
    new_eeg_data = 1'b1;
    if (accept) begin
      w.addr = BASE + exp_idx;
      w.data = conv_model(s);
      exp_q.push_back(w);
      exp_idx++;
    end
    tick();
    new_eeg_data = 1'b0;
  endtask

  // Write monitor: a write happens at the edge after a cycle with req && gnt
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_done) done_cnt++;
      if (mem_req && mem_gnt) begin
        wr_t w;
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", int'(mem_addr), w.addr);
          check("wr_data", int'($signed(mem_data)), w.data);
        end
      end
    end
  end

  logic [15:0] held_addr;
  logic [21:0] held_data;
  logic [15:0] conv_in [4];
  int          conv_exp [4];

  initial begin
    rst_n = 1'b0;
    start_eeg_load = 1'b0;
    new_eeg_data = 1'b0;
    eeg = '0;
    mem_gnt = 1'b0;
    repeat (2) tick();
    check("rst_req", int'(mem_req), 0);
    check("rst_addr", int'(mem_addr), BASE);
    check("rst_data", int'(mem_data), 0);
    check("rst_loading", int'(loading), 0);
    check("rst_done", int'(load_done), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_cnt", int'(sample_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Test 1: full epoch, grant tied high
    mem_gnt = 1'b1;
    pulse_start();
    check("t1_loading", int'(loading), 1);
    for (int i = 0; i < 3000; i++) begin
      send(16'((i * 37 + 1000) & 16'hFFFF), 1'b1);
      if (i == 0) check("t1_latency_req", int'(mem_req), 1);
      if (i < 2999) repeat (9) tick();
    end
    tick();
    check("t1_load_done", int'(load_done), 1);
    check("t1_loading_fall", int'(loading), 0);
    check("t1_cnt", int'(sample_cnt), 3000);
    tick();
    check("t1_done_pulse", int'(load_done), 0);
    check("t1_overrun", int'(overrun), 0);
    check("t1_writes", wr_cnt, 3000);
    check("t1_done_once", done_cnt, 1);
    send(16'h1234, 1'b0);
    check("t1_done_ignores", int'(mem_req), 0);

    // Test 2: conversion corner values
    conv_in[0] = 16'h8000; conv_exp[0] = 0;
    conv_in[1] = 16'h0000; conv_exp[1] = -524288;
    conv_in[2] = 16'hFFFF; conv_exp[2] = 524272;
    conv_in[3] = 16'h8001; conv_exp[3] = 16;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send(conv_in[i], 1'b1);
      check("t2_conv", int'($signed(mem_data)), conv_exp[i]);
      repeat (3) tick();
    end

    // Test 3: grant held off, second sample dropped
    pulse_start();
    mem_gnt = 1'b0;
    send(16'hA5A5, 1'b1);
    held_addr = mem_addr;
    held_data = mem_data;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) send(16'h1111, 1'b0);
      else tick();
      check("t3_req_hold", int'(mem_req), 1);
      check("t3_addr_hold", int'(mem_addr), int'(held_addr));
      check("t3_data_hold", int'(mem_data), int'(held_data));
      check("t3_cnt_hold", int'(sample_cnt), 0);
    end
    check("t3_overrun", int'(overrun), 1);
    mem_gnt = 1'b1;
    tick();
    check("t3_cnt_after", int'(sample_cnt), 1);
    check("t3_req_drop", int'(mem_req), 0);
    check("t3_overrun_sticky", int'(overrun), 1);

    // Test 4: new sample coincident with grant
    pulse_start();
    check("t4_overrun_clr", int'(overrun), 0);
    send(16'h4000, 1'b1);
    send(16'hC000, 1'b1);
    check("t4_req_held", int'(mem_req), 1);
    check("t4_addr_next", int'(mem_addr), BASE + 1);
    check("t4_cnt", int'(sample_cnt), 1);
    check("t4_overrun", int'(overrun), 0);
    tick();
    check("t4_req_end", int'(mem_req), 0);
    check("t4_cnt_end", int'(sample_cnt), 2);

    // Test 5: restart with a write pending
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      send(16'(i * 101), 1'b1);
      repeat (2) tick();
    end
    mem_gnt = 1'b0;
    send(16'h7777, 1'b0);
    send(16'h8888, 1'b0);
    check("t5_pending", int'(mem_req), 1);
    check("t5_overrun_set", int'(overrun), 1);
    check("t5_cnt100", int'(sample_cnt), 100);
    start_eeg_load = 1'b1;
    new_eeg_data = 1'b1;
    eeg = 16'h9999;
    tick();
    start_eeg_load = 1'b0;
    new_eeg_data = 1'b0;
    exp_idx = 0;
    check("t5_req_flush", int'(mem_req), 0);
    check("t5_cnt_clr", int'(sample_cnt), 0);
    check("t5_overrun_clr", int'(overrun), 0);
    check("t5_addr_base", int'(mem_addr), BASE);
    tick();
    check("t5_coincident_ignored", int'(mem_req), 0);
    mem_gnt = 1'b1;
    send(16'h0F0F, 1'b1);
    tick();
    check("t5_cnt_one", int'(sample_cnt), 1);

    // Test 6: asynchronous reset mid-load
    mem_gnt = 1'b0;
    send(16'h2222, 1'b1);
    send(16'h3333, 1'b0);
    check("t6_req_before", int'(mem_req), 1);
    void'(exp_q.pop_back());  // pending write is abandoned by reset
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_req", int'(mem_req), 0);
    check("t6_addr", int'(mem_addr), BASE);
    check("t6_data", int'(mem_data), 0);
    check("t6_loading", int'(loading), 0);
    check("t6_done", int'(load_done), 0);
    check("t6_overrun", int'(overrun), 0);
    check("t6_cnt", int'(sample_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();
    mem_gnt = 1'b1;
    send(16'h4444, 1'b0);
    tick();
    check("t6_idle_req", int'(mem_req), 0);
    check("t6_idle_cnt", int'(sample_cnt), 0);
    check("t6_idle_loading", int'(loading), 0);
    pulse_start();
    send(16'h5555, 1'b1);
    tick();
    check("t6_restart_cnt", int'(sample_cnt), 1);

    repeat (3) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
